tetris_move_sched: RTL
======================

Name: tetris_move_sched

Overview:
- Central sequencer between the player keys, the gravity timer and the gaming datapath.
- Debounces and edge-detects KeyLeft/KeyRight/KeyChange and generates gravity ticks.
- Arbitrates all move requests into one command stream with a valid/ready plus response handshake. Issues commands only during video blanking.
- Drives piece spawn (update_en) and game-over detection.

Parameters:
- TICK_DIV, 25000000, base gravity period in clk cycles (speed_sel=0).
- DEB_CYCLES, 250000, cycles a synchronized key must be stable before acceptance.
- CNT_W, 25, width of gravity and debounce counters; must hold TICK_DIV-1 and DEB_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- key_left  in  1  raw left key, asynchronous, active-high
- key_right  in  1  raw right key, asynchronous, active-high
- key_change  in  1  raw rotate key, asynchronous, active-high
- speed_sel  in  2  gravity period = TICK_DIV >> speed_sel
- frame_gate  in  1  high during vertical blanking; issue allowed
- cmd_valid  out  1  command offered to datapath
- cmd  out  2  0=DOWN, 1=LEFT, 2=RIGHT, 3=ROTATE
- cmd_ready  in  1  datapath accepts cmd this cycle
- resp_valid  in  1  one-cycle pulse: command evaluated
- resp_blocked  in  1  qualified by resp_valid; 1 = move collided and was not applied
- update_en  out  1  one-cycle spawn pulse to next-piece/gaming logic
- spawn_blocked  in  1  sampled the cycle after update_en; 1 = new piece overlaps map
- game_over  out  1  sticky game-over flag
- busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous, active-low. While rst=0:
  - state=INIT;
  - cmd_valid=0, cmd=0, update_en=0, game_over=0;
  - all pending flags, counters and synchronizers cleared.
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter resets on any change of the synchronized value. When it reaches DEB_CYCLES-1 the value is accepted.
  - A 0->1 transition of the accepted value sets that key's pending flag.
  - Pending saturates: repeated edges before issue produce one command.
- Gravity:
  - Counter counts 0..(TICK_DIV>>speed_sel)-1, then wraps to 0 and sets grav_pend.
  - Counter zeroed in SPAWN. Counter frozen in OVER.
  - A speed_sel change takes effect at the next compare. If the count is already past the new limit, the counter wraps at its maximum value.
- Pending clear vs set: a flag clears on the cycle its command handshakes (cmd_valid & cmd_ready). A new edge or tick in that same cycle wins, so the flag stays set.
- Arbitration priority: ROTATE > LEFT > RIGHT > DOWN (grav_pend). Fixed priority, evaluated in IDLE.
- FSM:
  - INIT -> SPAWN (one cycle after reset release).
  - SPAWN: update_en=1 for exactly one cycle -> CHECK.
  - CHECK: sample spawn_blocked. If 1 -> OVER, else -> IDLE.
  - IDLE: if frame_gate=1 and any pending flag is set, latch the winner into cmd, set cmd_valid=1 -> ISSUE. Otherwise stay.
  - ISSUE: hold cmd_valid and cmd stable until cmd_ready=1, then cmd_valid=0 next cycle -> WAIT. frame_gate dropping during ISSUE does not withdraw the command.
  - WAIT: on resp_valid:
    - if cmd=DOWN and resp_blocked=1 -> SPAWN (piece locked);
    - otherwise -> IDLE.
    - A blocked LEFT/RIGHT/ROTATE is discarded silently.
  - OVER: game_over=1, no further commands, update_en held 0, key edges ignored. Exit only by reset.
- Spurious inputs: resp_valid outside WAIT is ignored. cmd_ready outside ISSUE is ignored.
- Latency: with a pending flag set and frame_gate=1, cmd_valid rises 1 cycle after IDLE is entered. Minimum command turnaround, IDLE to IDLE, is 3 cycles with cmd_ready and resp_valid each arriving 1 cycle after the preceding step.
- busy=1 in every state except IDLE.
- Reset asserted mid-handshake aborts immediately. The datapath must treat rst as discarding any in-flight command.

Test Plan:
All scenarios use TICK_DIV=16, DEB_CYCLES=4, and a datapath model that accepts cmd_ready 1 cycle after cmd_valid and returns resp_valid 2 cycles later.
1. Release rst, frame_gate=1, spawn_blocked=0 -> update_en high exactly one cycle, 2 cycles after release. busy=0 thereafter. With speed_sel=0, cmd=0 (DOWN) issued every 16 cycles (±handshake).
2. key_left bounces 1,0,1 at 2-cycle spacing, then holds 1 -> exactly one LEFT command, issued 4+2 cycles after the final edge plus the IDLE cycle. No second command while held.
3. key_change and key_right accepted on the same cycle with grav_pend set, frame_gate=1 -> commands issued in order ROTATE(3), RIGHT(2), DOWN(0), each only after the previous response.
4. frame_gate=0 with pending LEFT -> cmd_valid stays 0. frame_gate rising -> cmd_valid=1 next cycle, cmd=1. Dropping frame_gate while cmd_ready=0 keeps cmd_valid=1.
5. DOWN with resp_blocked=1 -> update_en pulse. Then spawn_blocked=1 in CHECK -> game_over=1 and stays 1. Further key edges and gravity ticks produce no cmd_valid. rst low -> game_over=0 immediately (asynchronous).
6. speed_sel=2 -> DOWN commands every 4 cycles of count. Assert rst during ISSUE -> cmd_valid drops without waiting for a clock edge. Sequence restarts at INIT.

Source files
------------

// File: rtl/tetris_move_sched.sv
// Central move sequencer: debounces player keys, times gravity, arbitrates
// moves into one valid/ready/response command stream, and controls piece spawn.

module tetris_key_deb #(
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_rise
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        acc_d   = acc_q;
        cnt_d   = '0;
        // counter runs only while the synchronized level disagrees with the accepted one
        if (sync2_q != acc_q) begin
            if (cnt_q == DEB_LAST) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        key_rise = acc_d & ~acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

module tetris_move_sched #(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_change,
    input  logic [1:0] speed_sel,
    input  logic       frame_gate,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    input  logic       cmd_ready,
    input  logic       resp_valid,
    input  logic       resp_blocked,
    output logic       update_en,
    input  logic       spawn_blocked,
    output logic       game_over,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SPAWN,
        ST_CHECK,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OVER
    } state_e;

    typedef enum logic [1:0] {
        CMD_DOWN   = 2'd0,
        CMD_LEFT   = 2'd1,
        CMD_RIGHT  = 2'd2,
        CMD_ROTATE = 2'd3
    } cmd_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       key_rise;
    logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
    logic [CNT_W-1:0] grav_lim;
    logic             grav_tick;
    logic [3:0]       pend_q, pend_d;
    logic             handshake;
    cmd_e             win;

    state_e state_q, state_d;
    cmd_e   cmd_q, cmd_d;
    logic   cmd_valid_q, cmd_valid_d;
    logic   update_en_q, update_en_d;
    logic   game_over_q, game_over_d;
    logic   busy_q, busy_d;

    tetris_key_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_left (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_left),
        .key_rise (key_rise[0])
    );

    tetris_key_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_right (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_right),
        .key_rise (key_rise[1])
    );

    tetris_key_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_change (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_change),
        .key_rise (key_rise[2])
    );

    // Equality compare: a limit lowered below the current count wraps via overflow.
    always_comb begin
        grav_lim   = CNT_W'((TICK_DIV >> speed_sel) - 1);
        grav_cnt_d = grav_cnt_q;
        grav_tick  = 1'b0;
        if (state_q == ST_SPAWN) begin
            grav_cnt_d = '0;
        end else if (state_q != ST_OVER) begin
            if (grav_cnt_q == grav_lim) begin
                grav_cnt_d = '0;
                grav_tick  = 1'b1;
            end else begin
                grav_cnt_d = grav_cnt_q + CNT_ONE;
            end
        end
    end

    // Pending flags are indexed by command code; a set in the handshake cycle wins.
    always_comb begin
        handshake = (state_q == ST_ISSUE) && cmd_ready;
        pend_d    = pend_q;
        if (handshake) begin
            pend_d[cmd_q] = 1'b0;
        end
        if (state_q != ST_OVER) begin
            pend_d = pend_d | {key_rise[2], key_rise[1], key_rise[0], grav_tick};
        end
    end

    always_comb begin
        win = CMD_DOWN;
        if (pend_q[CMD_ROTATE]) begin
            win = CMD_ROTATE;
        end else if (pend_q[CMD_LEFT]) begin
            win = CMD_LEFT;
        end else if (pend_q[CMD_RIGHT]) begin
            win = CMD_RIGHT;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_INIT:  state_d = ST_SPAWN;
            ST_SPAWN: state_d = ST_CHECK;
            ST_CHECK: state_d = spawn_blocked ? ST_OVER : ST_IDLE;
            ST_IDLE: begin
                if (frame_gate && (pend_q != '0)) begin
                    state_d = ST_ISSUE;
                    cmd_d   = win;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_valid) begin
                    state_d = (cmd_q == CMD_DOWN && resp_blocked) ? ST_SPAWN : ST_IDLE;
                end
            end
            ST_OVER:  state_d = ST_OVER;
            default:  state_d = ST_INIT;
        endcase
        cmd_valid_d = (state_d == ST_ISSUE);
        update_en_d = (state_d == ST_SPAWN);
        game_over_d = (state_d == ST_OVER);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            cmd_q       <= CMD_DOWN;
            cmd_valid_q <= 1'b0;
            update_en_q <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b1;
            grav_cnt_q  <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            update_en_q <= update_en_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
            grav_cnt_q  <= grav_cnt_d;
            pend_q      <= pend_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign update_en = update_en_q;
    assign game_over = game_over_q;
    assign busy      = busy_q;

endmodule
